// File: rtl/writeback_regfile_if.sv
// Interface between the memory stage, decode, fetch and the writeback stage.
// The master side drives the committed entry, read addresses and redirect_ready.
interface writeback_regfile_if #(
    parameter int XLEN         = 64,
    parameter int RETIRE_CNT_W = 64
);
    logic [XLEN-1:0]         mem_result_q;
    logic [XLEN-1:0]         mem_result_plus_4_q;
    logic                    mem_result_valid_q;
    logic                    mem_result_is_branch_addr_q;
    logic                    mem_write_to_rd_q;
    logic [4:0]              mem_rd_q;
    logic                    mem_should_end_program_q;
    logic [4:0]              rs1_addr;
    logic [XLEN-1:0]         rs1_data;
    logic [4:0]              rs2_addr;
    logic [XLEN-1:0]         rs2_data;
    logic                    redirect_valid;
    logic [XLEN-1:0]         redirect_pc;
    logic                    redirect_ready;
    logic                    halted;
    logic [RETIRE_CNT_W-1:0] retired_count;
    logic                    wb_stall;

    modport master (
        output mem_result_q, mem_result_plus_4_q, mem_result_valid_q,
        output mem_result_is_branch_addr_q, mem_write_to_rd_q, mem_rd_q,
        output mem_should_end_program_q, rs1_addr, rs2_addr, redirect_ready,
        input  rs1_data, rs2_data, redirect_valid, redirect_pc,
        input  halted, retired_count, wb_stall
    );

    modport slave (
        input  mem_result_q, mem_result_plus_4_q, mem_result_valid_q,
        input  mem_result_is_branch_addr_q, mem_write_to_rd_q, mem_rd_q,
        input  mem_should_end_program_q, rs1_addr, rs2_addr, redirect_ready,
        output rs1_data, rs2_data, redirect_valid, redirect_pc,
        output halted, retired_count, wb_stall
    );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage: commits results into the integer register file, issues
// branch redirects to fetch, counts retired instructions and latches halt.
module writeback_regfile #(
    parameter int XLEN         = 64,
    parameter int NUM_REGS     = 32,
    parameter int RETIRE_CNT_W = 64
) (
    input logic              clk,
    input logic              rst,
    writeback_regfile_if.slave bus
);
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [XLEN-1:0]         regs [NUM_REGS];
    logic                    redirect_valid_q;
    logic [XLEN-1:0]         redirect_pc_q;
    logic [RETIRE_CNT_W-1:0] retired_q;
    logic                    is_branch;
    logic                    stall;
    logic                    commit;
    logic                    wr_en;
    logic [XLEN-1:0]         wr_data;

    // A new branch cannot commit while fetch still owes us an accept.
    always_comb begin
        is_branch = bus.mem_result_valid_q && bus.mem_result_is_branch_addr_q;
        stall     = redirect_valid_q && !bus.redirect_ready && is_branch;
        commit    = bus.mem_result_valid_q && (state == RUN) && !stall;
        wr_en     = commit && bus.mem_write_to_rd_q && (bus.mem_rd_q != 5'd0);
        wr_data   = bus.mem_result_is_branch_addr_q ? bus.mem_result_plus_4_q
                                                    : bus.mem_result_q;
    end

    // Read ports see this cycle's commit so decode never reads stale data.
    always_comb begin
        if (wr_en && bus.rs1_addr == bus.mem_rd_q) begin
            bus.rs1_data = wr_data;
        end else if (bus.rs1_addr == 5'd0) begin
            bus.rs1_data = '0;
        end else begin
            bus.rs1_data = regs[bus.rs1_addr];
        end
        if (wr_en && bus.rs2_addr == bus.mem_rd_q) begin
            bus.rs2_data = wr_data;
        end else if (bus.rs2_addr == 5'd0) begin
            bus.rs2_data = '0;
        end else begin
            bus.rs2_data = regs[bus.rs2_addr];
        end
    end

    // Register file storage; x0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.mem_rd_q] <= wr_data;
        end
    end

    // Redirect holds until accepted; a committing branch reloads it at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else if (commit && bus.mem_result_is_branch_addr_q) begin
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= {bus.mem_result_q[XLEN-1:1], 1'b0};
        end else if (redirect_valid_q && bus.redirect_ready) begin
            redirect_valid_q <= 1'b0;
        end
    end

    // Every commit retires one instruction, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else if (commit) begin
            retired_q <= retired_q + RETIRE_CNT_W'(1);
        end
    end

    // Run/halt state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Halt is absorbing; only an ending entry that commits leaves RUN.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN:     if (commit && bus.mem_should_end_program_q) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // Stage outputs.
    always_comb begin
        bus.halted         = (state == HALTED);
        bus.wb_stall       = stall;
        bus.redirect_valid = redirect_valid_q;
        bus.redirect_pc    = redirect_pc_q;
        bus.retired_count  = retired_q;
    end
endmodule
